// File: rtl/adder_sum_acc.sv
// Accumulates BURST consecutive {carry, sum} adder results into one wide total and
// presents it on a valid/ready port. Define ADDER_ACC_SAT_EN to saturate instead of wrap.
module adder_sum_acc #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_sum,
   input  logic              in_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_total,
   output logic              out_ovf
);

   typedef enum logic {StAcc, StDone} state_e;

   localparam logic [7:0] BurstCnt = 8'(BURST);

   state_e             r_state, w_state_d;
   logic [ACC_W-1:0]   r_acc, w_acc_d;
   logic [7:0]         r_cnt, w_cnt_d;
   logic               r_ovf, w_ovf_d;
   logic [ACC_W:0]     w_sample;
   logic [ACC_W:0]     w_sum;
   logic               w_accept;

   // One extra bit above ACC_W catches the carry out of the running total.
   assign w_sample = {{(ACC_W - DATA_W){1'b0}}, in_carry, in_sum};
   assign w_sum    = {1'b0, r_acc} + w_sample;
   assign w_accept = in_valid && (r_state == StAcc);

   always_comb begin
      w_state_d = r_state;
      w_acc_d   = r_acc;
      w_cnt_d   = r_cnt;
      w_ovf_d   = r_ovf;
      unique case (r_state)
         StAcc: begin
            if (w_accept) begin
               w_cnt_d = r_cnt + 8'd1;
               w_ovf_d = r_ovf | w_sum[ACC_W];
`ifdef ADDER_ACC_SAT_EN
               if (r_ovf || w_sum[ACC_W]) begin
                  w_acc_d = '1;
               end else begin
                  w_acc_d = w_sum[ACC_W-1:0];
               end
`else
               w_acc_d = w_sum[ACC_W-1:0];
`endif
               if (w_cnt_d == BurstCnt) begin
                  w_state_d = StDone;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               w_acc_d   = '0;
               w_cnt_d   = '0;
               w_ovf_d   = 1'b0;
               w_state_d = StAcc;
            end
         end
         default: w_state_d = StAcc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StAcc;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_acc   <= w_acc_d;
         r_cnt   <= w_cnt_d;
         r_ovf   <= w_ovf_d;
      end
   end

   assign in_ready  = (r_state == StAcc);
   assign out_valid = (r_state == StDone);
   assign out_total = r_acc;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_sum_acc.sv
// Directed bench for adder_sum_acc: a 16-bit instance for the main scenarios and a
// 10-bit instance sharing the same inputs for the overflow scenario.
module tb_adder_sum_acc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_sum;
   logic        in_carry;
   logic        out_ready;
   logic        in_ready, out_valid, out_ovf;
   logic [15:0] out_total;
   logic        o_in_ready, o_out_valid, o_out_ovf;
   logic [9:0]  o_out_total;

   int checks;
   int failures;

`ifdef ADDER_ACC_SAT_EN
   localparam int OvfTotalExp = 1023;
`else
   localparam int OvfTotalExp = 1020;
`endif

   adder_sum_acc #(.DATA_W(8), .ACC_W(16), .BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_total (out_total),
      .out_ovf   (out_ovf)
   );

   adder_sum_acc #(.DATA_W(8), .ACC_W(10), .BURST(4)) dut_ovf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (o_in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (o_out_valid),
      .out_ready (out_ready),
      .out_total (o_out_total),
      .out_ovf   (o_out_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called at a negedge while in ACC; the following posedge accepts the sample.
   task automatic push(input logic [7:0] s, input logic c);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready got=%b exp=1", in_ready); failures++;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL reset_out_valid got=%b exp=0", out_valid); failures++;
      end
      checks++;
      if (out_total !== 16'd0) begin
         $display("FAIL reset_out_total got=%0d exp=0", out_total); failures++;
      end
      checks++;
      if (out_ovf !== 1'b0) begin
         $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); failures++;
      end
      // out_ready while idle must not disturb anything
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_total !== 16'd0) begin
         $display("FAIL idle_out_ready got rdy=%b vld=%b tot=%0d exp rdy=1 vld=0 tot=0",
                  in_ready, out_valid, out_total);
         failures++;
      end
   endtask

   task automatic test_basic();
      push(8'd10, 1'b0);
      push(8'd20, 1'b0);
      push(8'd30, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL basic_early_valid got=%b exp=0", out_valid); failures++;
      end
      push(8'd40, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin
         $display("FAIL basic_valid got=%b exp=1", out_valid); failures++;
      end
      checks++;
      if (out_total !== 16'd100) begin
         $display("FAIL basic_total got=%0d exp=100", out_total); failures++;
      end
      checks++;
      if (out_ovf !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL basic_ovf_ready got ovf=%b rdy=%b exp ovf=0 rdy=0", out_ovf, in_ready);
         failures++;
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL basic_consume got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
         failures++;
      end
   endtask

   task automatic test_carry_overflow();
      for (int i = 0; i < 4; i++) begin
         push(8'hFF, 1'b1);
         if (i < 3) begin
            repeat (2) @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
               $display("FAIL carry_gap_valid idx=%0d got=%b exp=0", i, out_valid); failures++;
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_total !== 16'd2044 || out_ovf !== 1'b0) begin
         $display("FAIL carry_total got vld=%b tot=%0d ovf=%b exp vld=1 tot=2044 ovf=0",
                  out_valid, out_total, out_ovf);
         failures++;
      end
      checks++;
      if (o_out_valid !== 1'b1 || o_out_total !== 10'(OvfTotalExp) || o_out_ovf !== 1'b1) begin
         $display("FAIL ovf_total got vld=%b tot=%0d ovf=%b exp vld=1 tot=%0d ovf=1",
                  o_out_valid, o_out_total, o_out_ovf, OvfTotalExp);
         failures++;
      end
      consume();
      repeat (4) push(8'd1, 1'b0);
      checks++;
      if (o_out_valid !== 1'b1 || o_out_total !== 10'd4 || o_out_ovf !== 1'b0) begin
         $display("FAIL ovf_next_burst got vld=%b tot=%0d ovf=%b exp vld=1 tot=4 ovf=0",
                  o_out_valid, o_out_total, o_out_ovf);
         failures++;
      end
      consume();
   endtask

   task automatic test_back_pressure();
      push(8'd1, 1'b0);
      push(8'd2, 1'b0);
      push(8'd3, 1'b0);
      push(8'd4, 1'b0);
      in_valid = 1'b1;
      in_sum   = 8'd7;
      in_carry = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_total !== 16'd10 || in_ready !== 1'b0) begin
            $display("FAIL bp_hold cyc=%0d got vld=%b tot=%0d rdy=%b exp vld=1 tot=10 rdy=0",
                     i, out_valid, out_total, in_ready);
            failures++;
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_total !== 16'd7 || out_valid !== 1'b0) begin
         $display("FAIL bp_first_accept got tot=%0d vld=%b exp tot=7 vld=0", out_total, out_valid);
         failures++;
      end
      repeat (3) push(8'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_total !== 16'd7) begin
         $display("FAIL bp_next_burst got vld=%b tot=%0d exp vld=1 tot=7", out_valid, out_total);
         failures++;
      end
      consume();
   endtask

   task automatic test_mid_reset();
      push(8'd50, 1'b0);
      push(8'd60, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_total !== 16'd0 || in_ready !== 1'b1) begin
         $display("FAIL midrst_clear got tot=%0d rdy=%b exp tot=0 rdy=1", out_total, in_ready);
         failures++;
      end
      push(8'd1, 1'b0);
      push(8'd2, 1'b0);
      push(8'd3, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL midrst_early_valid got=%b exp=0", out_valid); failures++;
      end
      push(8'd4, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_total !== 16'd10 || out_ovf !== 1'b0) begin
         $display("FAIL midrst_total got vld=%b tot=%0d ovf=%b exp vld=1 tot=10 ovf=0",
                  out_valid, out_total, out_ovf);
         failures++;
      end
      consume();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = 8'd0;
      in_carry  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_carry_overflow();
      test_back_pressure();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
